// File: rtl/control_unit.sv
// rtl/control_unit.sv - multi-cycle instruction sequencer with memory-wait timeout.
// All outputs are registers loaded from the next state, so they line up with c_o_state.
module control_unit #(
   parameter int OPCODE_WIDTH = 6,
   parameter int CNT_WIDTH    = 32,
   parameter int MEM_TIMEOUT  = 16
) (
   input  logic                    c_clk,
   input  logic                    c_rst,
   input  logic                    c_i_start,
   input  logic                    c_i_halt,
   input  logic [OPCODE_WIDTH-1:0] c_i_opcode,
   input  logic                    c_i_mem_ready,
   output logic                    c_o_ce,
   output logic                    c_o_RegDst,
   output logic                    c_o_RegWrite,
   output logic                    c_o_Branch,
   output logic                    c_o_ALUSrc,
   output logic                    c_o_MemRead,
   output logic                    c_o_MemWrite,
   output logic                    c_o_MemtoReg,
   output logic                    c_o_busy,
   output logic [2:0]              c_o_state,
   output logic                    c_o_illegal,
   output logic                    c_o_err,
   output logic [CNT_WIDTH-1:0]    c_o_retired
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5
   } state_t;

   localparam int TW = $clog2(MEM_TIMEOUT) + 1;
   localparam logic [OPCODE_WIDTH-1:0] OP_R    = OPCODE_WIDTH'(6'b000000);
   localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(6'b001000);
   localparam logic [OPCODE_WIDTH-1:0] OP_LW   = OPCODE_WIDTH'(6'b100011);
   localparam logic [OPCODE_WIDTH-1:0] OP_SW   = OPCODE_WIDTH'(6'b101011);
   localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = OPCODE_WIDTH'(6'b000100);

   state_t                  state_q, state_d;
   logic [OPCODE_WIDTH-1:0] opc_q, opc_d;
   logic [TW-1:0]           wait_q, wait_d;
   logic                    err_q, err_d;
   logic [CNT_WIDTH-1:0]    retired_q, retired_d;
   logic                    ce_q, ce_d, regdst_q, regdst_d, regwrite_q, regwrite_d;
   logic                    branch_q, branch_d, alusrc_q, alusrc_d;
   logic                    memread_q, memread_d, memwrite_q, memwrite_d;
   logic                    memtoreg_q, memtoreg_d, illegal_q, illegal_d, busy_q, busy_d;
   logic                    boundary, retire, in_instr;

   always_ff @(posedge c_clk or negedge c_rst) begin
      if (!c_rst) begin
         state_q    <= S_IDLE;
         opc_q      <= '0;
         wait_q     <= '0;
         err_q      <= 1'b0;
         retired_q  <= '0;
         ce_q       <= 1'b0;
         regdst_q   <= 1'b0;
         regwrite_q <= 1'b0;
         branch_q   <= 1'b0;
         alusrc_q   <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         illegal_q  <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         opc_q      <= opc_d;
         wait_q     <= wait_d;
         err_q      <= err_d;
         retired_q  <= retired_d;
         ce_q       <= ce_d;
         regdst_q   <= regdst_d;
         regwrite_q <= regwrite_d;
         branch_q   <= branch_d;
         alusrc_q   <= alusrc_d;
         memread_q  <= memread_d;
         memwrite_q <= memwrite_d;
         memtoreg_q <= memtoreg_d;
         illegal_q  <= illegal_d;
         busy_q     <= busy_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      opc_d     = opc_q;
      wait_d    = wait_q;
      err_d     = err_q;
      retired_d = retired_q;
      boundary  = 1'b0;
      retire    = 1'b0;
      case (state_q)
         S_IDLE:   if (c_i_start) state_d = S_FETCH;
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            opc_d   = c_i_opcode;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            wait_d = '0;
            if (opc_q == OP_R || opc_q == OP_ADDI) begin
               state_d = S_WB;
            end else if (opc_q == OP_LW || opc_q == OP_SW) begin
               state_d = S_MEM;
            end else begin
               boundary = 1'b1;
               retire   = (opc_q == OP_BEQ);
            end
         end
         S_MEM: begin
            if (c_i_mem_ready) begin
               if (opc_q == OP_LW) begin
                  state_d = S_WB;
               end else begin
                  boundary = 1'b1;
                  retire   = 1'b1;
               end
            end else if (wait_q == TW'(MEM_TIMEOUT - 1)) begin
               // Timed-out access is abandoned without retiring.
               boundary = 1'b1;
               err_d    = 1'b1;
            end else begin
               wait_d = wait_q + TW'(1);
            end
         end
         S_WB: begin
            boundary = 1'b1;
            retire   = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      if (boundary) state_d = c_i_halt ? S_IDLE : S_FETCH;
      if (retire) retired_d = retired_q + CNT_WIDTH'(1);
   end

   // Outputs are decoded from next state and next opcode so they register in step with it.
   always_comb begin
      in_instr   = (state_d == S_EXEC) || (state_d == S_MEM) || (state_d == S_WB);
      ce_d       = (state_d == S_FETCH);
      busy_d     = (state_d != S_IDLE);
      regdst_d   = in_instr && (opc_d == OP_R);
      alusrc_d   = in_instr && (opc_d == OP_ADDI || opc_d == OP_LW || opc_d == OP_SW);
      memtoreg_d = in_instr && (opc_d == OP_LW);
      branch_d   = (state_d == S_EXEC) && (opc_d == OP_BEQ);
      memread_d  = (state_d == S_MEM) && (opc_d == OP_LW);
      memwrite_d = (state_d == S_MEM) && (opc_d == OP_SW);
      regwrite_d = (state_d == S_WB);
      illegal_d  = (state_d == S_EXEC) && !(opc_d == OP_R || opc_d == OP_ADDI ||
                   opc_d == OP_LW || opc_d == OP_SW || opc_d == OP_BEQ);
   end

   assign c_o_state    = state_q;
   assign c_o_ce       = ce_q;
   assign c_o_RegDst   = regdst_q;
   assign c_o_RegWrite = regwrite_q;
   assign c_o_Branch   = branch_q;
   assign c_o_ALUSrc   = alusrc_q;
   assign c_o_MemRead  = memread_q;
   assign c_o_MemWrite = memwrite_q;
   assign c_o_MemtoReg = memtoreg_q;
   assign c_o_busy     = busy_q;
   assign c_o_illegal  = illegal_q;
   assign c_o_err      = err_q;
   assign c_o_retired  = retired_q;

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - randomized instruction-trace bench for control_unit.
// Each instruction is expanded into its expected per-cycle output trace from the ISA rules.
module tb_control_unit;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start, halt, ready;
   logic [5:0] opcode;
   logic       ce, regdst, regwrite, branch, alusrc, memread, memwrite, memtoreg;
   logic       busy, illegal, err;
   logic [2:0] state;
   logic [3:0] retired;

   int checks = 0;
   int errors = 0;

   control_unit #(.OPCODE_WIDTH(6), .CNT_WIDTH(4), .MEM_TIMEOUT(16)) dut (
      .c_clk(clk), .c_rst(rst_n), .c_i_start(start), .c_i_halt(halt),
      .c_i_opcode(opcode), .c_i_mem_ready(ready),
      .c_o_ce(ce), .c_o_RegDst(regdst), .c_o_RegWrite(regwrite), .c_o_Branch(branch),
      .c_o_ALUSrc(alusrc), .c_o_MemRead(memread), .c_o_MemWrite(memwrite),
      .c_o_MemtoReg(memtoreg), .c_o_busy(busy), .c_o_state(state),
      .c_o_illegal(illegal), .c_o_err(err), .c_o_retired(retired)
   );

   always #5 clk = ~clk;

   // {state, busy, ce, RegDst, RegWrite, Branch, ALUSrc, MemRead, MemWrite, MemtoReg, illegal, err}
   logic [13:0] obs;
   assign obs = {state, busy, ce, regdst, regwrite, branch, alusrc,
                 memread, memwrite, memtoreg, illegal, err};

   typedef struct {
      logic [13:0] outs;
      logic [3:0]  ret;
      logic        start, halt, ready;
      logic [5:0]  opc;
   } ent_t;

   ent_t q[$];
   int   model_ret;
   bit   model_err;
   bit   in_idle;

   task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL %s obs=%h exp=%h at %0t", tag, o, e, $time);
      end
   endtask

   // 0=R 1=addi 2=lw 3=sw 4=beq 5=illegal
   function automatic int kind_of(input logic [5:0] op);
      case (op)
         6'b000000: return 0;
         6'b001000: return 1;
         6'b100011: return 2;
         6'b101011: return 3;
         6'b000100: return 4;
         default:   return 5;
      endcase
   endfunction

   function automatic ent_t mk(input int st, input int k, input bit rw, input bit br,
                               input bit mr, input bit mw, input bit il);
      ent_t e;
      bit   stat;
      stat   = (st >= 3);
      e.outs = {3'(st), st != 0, st == 1,
                stat && k == 0, rw, br, stat && (k == 1 || k == 2 || k == 3),
                mr, mw, stat && k == 2, il, model_err};
      e.ret   = 4'(model_ret % 16);
      e.start = 1'($urandom_range(0, 1));
      e.halt  = 1'($urandom_range(0, 1));
      e.ready = 1'($urandom_range(0, 1));
      e.opc   = 6'($urandom_range(0, 63));
      return e;
   endfunction

   task automatic gen(input logic [5:0] op, input int w, input bit to, input bit h, input int idles);
      ent_t e;
      int   k, nm;
      k = kind_of(op);
      if (in_idle) begin
         for (int i = 0; i < idles; i++) begin
            e = mk(0, 0, 0, 0, 0, 0, 0); e.start = 1'b0; q.push_back(e);
         end
         e = mk(0, 0, 0, 0, 0, 0, 0); e.start = 1'b1; q.push_back(e);
      end
      q.push_back(mk(1, 0, 0, 0, 0, 0, 0));
      e = mk(2, 0, 0, 0, 0, 0, 0); e.opc = op; q.push_back(e);
      e = mk(3, k, 0, k == 4, 0, 0, k == 5);
      if (k >= 4) begin
         e.halt = h; q.push_back(e);
         if (k == 4) model_ret++;
      end else if (k <= 1) begin
         q.push_back(e);
         e = mk(5, k, 1, 0, 0, 0, 0); e.halt = h; q.push_back(e);
         model_ret++;
      end else begin
         q.push_back(e);
         nm = to ? 16 : w + 1;
         for (int i = 0; i < nm; i++) begin
            e = mk(4, k, 0, 0, k == 2, k == 3, 0);
            e.ready = !to && (i == nm - 1);
            if (i == nm - 1 && (to || k == 3)) e.halt = h;
            q.push_back(e);
         end
         if (to) begin
            model_err = 1'b1;
         end else begin
            if (k == 2) begin
               e = mk(5, k, 1, 0, 0, 0, 0); e.halt = h; q.push_back(e);
            end
            model_ret++;
         end
      end
      in_idle = h;
   endtask

   task automatic run(input bit stop_mem);
      ent_t e;
      while (q.size() > 0) begin
         e = q.pop_front();
         check("outs", 32'(obs), 32'(e.outs));
         check("retired", 32'(retired), 32'(e.ret));
         start = e.start; halt = e.halt; ready = e.ready; opcode = e.opc;
         if (stop_mem && e.outs[13:11] == 3'd4) break;
         @(posedge clk); #1;
      end
      q.delete();
   endtask

   logic [5:0] ops [5] = '{6'b000000, 6'b001000, 6'b100011, 6'b101011, 6'b000100};

   initial begin
      logic [5:0] op;
      int k;
      rst_n = 1'b0; start = 1'b1; halt = 1'b0; ready = 1'b0; opcode = 6'd0;
      model_ret = 0; model_err = 1'b0; in_idle = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("reset_outs", 32'(obs), 32'd0);
      check("reset_ret", 32'(retired), 32'd0);
      rst_n = 1'b1;
      start = 1'b0;
      @(posedge clk); #1;
      check("post_reset_idle", 32'(obs), 32'd0);

      gen(6'b000000, 0, 0, 0, 0);
      gen(6'b100011, 2, 0, 0, 0);
      gen(6'b101011, 0, 1, 0, 0);
      gen(6'b111111, 0, 0, 0, 0);
      gen(6'b000100, 0, 0, 1, 1);
      gen(6'b100011, 0, 0, 1, 0);
      run(0);

      for (int n = 0; n < 60; n++) begin
         k = $urandom_range(0, 5);
         if (k < 5) op = ops[k];
         else begin
            do op = 6'($urandom_range(0, 63)); while (kind_of(op) != 5);
         end
         gen(op, $urandom_range(0, 3), $urandom_range(0, 7) == 0,
             $urandom_range(0, 3) == 0, $urandom_range(0, 2));
         run(0);
      end

      // Reset in the middle of a load's memory wait.
      gen(6'b100011, 3, 0, 0, 0);
      run(1);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_outs", 32'(obs), 32'd0);
      check("async_reset_ret", 32'(retired), 32'd0);
      @(posedge clk); #1;
      check("reset_hold_outs", 32'(obs), 32'd0);
      rst_n = 1'b1; start = 1'b0; ready = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         check("idle_wait_start", 32'(obs), 32'd0);
      end
      model_ret = 0; model_err = 1'b0; in_idle = 1'b1;
      gen(6'b001000, 0, 0, 1, 0);
      run(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
